af_setpoint_ctrl: RTL and testbench
===================================

# af_setpoint_ctrl

Parametrised amplitude/frequency setpoint controller for the rocking drive: holds amplitude A and frequency F as W-bit setpoints and adjusts them on rising edges of up/down requests from the sensor/decision logic. Both setpoints move in configurable steps with saturation. A holdoff timer rate-limits adjustments, and zero/limit flags are provided for the motor-drive sequencer. Replaces the fixed 4-bit, decrement-only A/F counter pair with a fully synchronous, single-clock design.

## Interface
- W, 4: setpoint width in bits
- A_INIT, 5: amplitude value loaded at reset
- F_INIT, 5: frequency value loaded at reset
- A_MAX, 2**W-1: amplitude upper limit
- F_MAX, 2**W-1: frequency upper limit
- STEP, 1: increment/decrement size for both channels, 1..A_MAX
- HOLDOFF, 16: cycles after an applied change during which new requests are discarded, ≥1
- DECAY_CYCLES, 1024: idle cycles per automatic amplitude decrement (only with AF_AUTO_DECAY_EN)
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- a_up  in  1  amplitude increase request, level; acted on at its rising edge
- a_down  in  1  amplitude decrease request, level; acted on at its rising edge
- f_up  in  1  frequency increase request, level; acted on at its rising edge
- f_down  in  1  frequency decrease request, level; acted on at its rising edge
- A  out  W  amplitude setpoint
- F  out  W  frequency setpoint
- f_zero  out  1  F == 0
- af_zero  out  1  A == 0 and F == 0
- a_at_max  out  1  A == A_MAX
- f_at_max  out  1  F == F_MAX
- busy  out  1  holdoff active

## Operation
- All request inputs are synchronous to clk; synchronisers are external.
- Edge detection: each request has a previous-value register. edge = in & ~prev.
- State machine: IDLE and HOLD.
- IDLE:
  - Per channel, exactly one of up_edge/down_edge applies +STEP/−STEP. Both edges in the same cycle on one channel cancel with no change.
  - A and F requests in the same cycle are both applied.
  - If any change is applied, load the holdoff counter with HOLDOFF−1 and go to HOLD.
  - A request that produces no value change is still "applied", e.g. up at the limit. It enters HOLD.
- HOLD:
  - busy=1. Edges are discarded, not queued; prev registers keep tracking.
  - The counter decrements each cycle. Return to IDLE on the cycle after it reads 0.
- Arithmetic: compute in W+1 bits.
  - Up: min(X+STEP, X_MAX).
  - Down: X<STEP ? 0 : X−STEP.
  - No wrap-around.
- Flags are combinational from A/F registers.
- Reset asserted mid-operation aborts HOLD immediately and restores reset values.

## Timing
- Reset values:
  - A=A_INIT, F=F_INIT.
  - busy=0, state IDLE.
  - prev registers=0, so an input already high at reset release counts as an edge on the first clock.
  - Flags follow from A_INIT/F_INIT.
- Latency: a request high before clock edge k (prev=0) updates A/F at edge k, visible after k. busy rises at edge k.
- busy stays high for exactly HOLDOFF cycles. The first edge accepted again is at edge k+HOLDOFF.
- Throughput: at most one update per channel per HOLDOFF cycles.

## Configuration
- AF_AUTO_DECAY_EN defined: adds a decay counter of width clog2(DECAY_CYCLES).
  - The counter runs only in IDLE and is cleared by any applied request and by reset.
  - On reaching DECAY_CYCLES−1, A decreases by STEP (saturating at 0) and the counter restarts.
  - Decay does not enter HOLD.
  - A request edge in the same cycle wins and the decay decrement is dropped.
  - With A=0, decay has no effect.
- AF_AUTO_DECAY_EN undefined: no decay logic. A changes only on requests, and DECAY_CYCLES is ignored.

## Test plan
- Reset release with defaults (W=4, A_INIT=F_INIT=5) -> A=5, F=5, flags 0, busy=0; reset asserted during HOLD -> A/F back to 5 asynchronously, busy=0.
- Single a_down pulse -> A=4 after the next edge; busy high exactly 16 cycles; a second a_down 5 cycles later -> discarded, A stays 4.
- f_down pulses spaced 20 cycles from F=5 with STEP=2 -> F=3, 1, 0, 0; f_zero=1 after the third pulse; with A driven to 0, af_zero=1.
- a_up pulses from A=14 (A_MAX=15, STEP=2) -> A=15, stays 15, a_at_max=1; a_up+a_down same cycle -> no change and HOLD entered; a_up+f_up same cycle -> both increment.
- Input held high across reset release -> counted as one edge on the first clock; held high for 100 cycles -> only one update.
- With AF_AUTO_DECAY_EN, DECAY_CYCLES=8, A=3, no requests -> A=2, 1, 0 at 8-cycle intervals, then stays 0; request on the terminal cycle -> decay dropped and counter restarts.

Source files
------------

// File: rtl/af_setpoint_ctrl.sv
// Amplitude/frequency setpoint controller: rising-edge up/down requests, saturating steps,
// holdoff rate limiting. Define AF_AUTO_DECAY_EN to add idle-time amplitude decay.
module af_setpoint_ctrl #(
  parameter int W            = 4,
  parameter int A_INIT       = 5,
  parameter int F_INIT       = 5,
  parameter int A_MAX        = 2**W - 1,
  parameter int F_MAX        = 2**W - 1,
  parameter int STEP         = 1,
  parameter int HOLDOFF      = 16,
  parameter int DECAY_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_up,
  input  logic         a_down,
  input  logic         f_up,
  input  logic         f_down,
  output logic [W-1:0] A,
  output logic [W-1:0] F,
  output logic         f_zero,
  output logic         af_zero,
  output logic         a_at_max,
  output logic         f_at_max,
  output logic         busy
);

  localparam int            HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [W:0]    STEP_X    = (W+1)'(STEP);
  localparam logic [W:0]    A_LIM     = (W+1)'(A_MAX);
  localparam logic [W:0]    F_LIM     = (W+1)'(F_MAX);
  localparam logic [W-1:0]  A_RST     = W'(A_INIT);
  localparam logic [W-1:0]  F_RST     = W'(F_INIT);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [W-1:0]  a_nxt, f_nxt;
  logic          a_up_q, a_down_q, f_up_q, f_down_q;
  logic          a_up_edge, a_down_edge, f_up_edge, f_down_edge;
  logic          any_edge, accept;

`ifdef AF_AUTO_DECAY_EN
  localparam int            DW         = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_CYCLES - 1);
  logic [DW-1:0] decay_cnt, decay_nxt;
`endif

  // Arithmetic is one bit wider than the setpoint so the limit tests cannot wrap.
  function automatic logic [W-1:0] step_up(input logic [W-1:0] x, input logic [W:0] lim);
    logic [W:0] sum;
    sum = {1'b0, x} + STEP_X;
    return (sum > lim) ? lim[W-1:0] : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] step_down(input logic [W-1:0] x);
    logic [W:0] diff;
    diff = {1'b0, x} - STEP_X;
    return ({1'b0, x} < STEP_X) ? '0 : diff[W-1:0];
  endfunction

  assign a_up_edge   = a_up & ~a_up_q;
  assign a_down_edge = a_down & ~a_down_q;
  assign f_up_edge   = f_up & ~f_up_q;
  assign f_down_edge = f_down & ~f_down_q;
  assign any_edge    = a_up_edge | a_down_edge | f_up_edge | f_down_edge;
  // The last holdoff cycle already accepts edges, so the next update lands HOLDOFF edges later.
  assign accept      = (state == IDLE) || (hold_cnt == '0);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    a_nxt     = A;
    f_nxt     = F;
`ifdef AF_AUTO_DECAY_EN
    decay_nxt = decay_cnt;
`endif
    if (state == HOLD && hold_cnt != '0) hold_nxt = hold_cnt - HW'(1);
    if (accept && any_edge) begin
      state_nxt = HOLD;
      hold_nxt  = HOLD_LOAD;
      if (a_up_edge && !a_down_edge)      a_nxt = step_up(A, A_LIM);
      else if (a_down_edge && !a_up_edge) a_nxt = step_down(A);
      if (f_up_edge && !f_down_edge)      f_nxt = step_up(F, F_LIM);
      else if (f_down_edge && !f_up_edge) f_nxt = step_down(F);
`ifdef AF_AUTO_DECAY_EN
      decay_nxt = '0;
`endif
    end else begin
      if (accept) state_nxt = IDLE;
`ifdef AF_AUTO_DECAY_EN
      if (state == IDLE) begin
        if (decay_cnt == DECAY_LAST) begin
          a_nxt     = step_down(A);
          decay_nxt = '0;
        end else begin
          decay_nxt = decay_cnt + DW'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      A        <= A_RST;
      F        <= F_RST;
      a_up_q   <= 1'b0;
      a_down_q <= 1'b0;
      f_up_q   <= 1'b0;
      f_down_q <= 1'b0;
`ifdef AF_AUTO_DECAY_EN
      decay_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      A        <= a_nxt;
      F        <= f_nxt;
      a_up_q   <= a_up;
      a_down_q <= a_down;
      f_up_q   <= f_up;
      f_down_q <= f_down;
`ifdef AF_AUTO_DECAY_EN
      decay_cnt <= decay_nxt;
`endif
    end
  end

  assign f_zero   = (F == '0);
  assign af_zero  = (A == '0) && (F == '0);
  assign a_at_max = ({1'b0, A} == A_LIM);
  assign f_at_max = ({1'b0, F} == F_LIM);
  assign busy     = (state == HOLD);

endmodule

// File: tb/tb_af_setpoint_ctrl.sv
// Bench for af_setpoint_ctrl: two configurations share the request inputs and are compared
// every cycle against a cycle-count based reference model, plus directed boundary checks.
module tb_af_setpoint_ctrl;

  localparam int W     = 4;
  localparam int DECAY = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         a_up = 1'b0, a_down = 1'b0, f_up = 1'b0, f_down = 1'b0;
  logic [W-1:0] a1, f1, a2, f2;
  logic         f_zero1, af_zero1, a_at_max1, f_at_max1, busy1;
  logic         f_zero2, af_zero2, a_at_max2, f_at_max2, busy2;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, setpoints plus the first edge index at which a request is accepted.
  int   m_step [2] = '{1, 2};
  int   m_hold [2] = '{16, 12};
  int   m_amax [2] = '{15, 15};
  int   m_fmax [2] = '{15, 13};
  int   m_a [2];
  int   m_f [2];
  int   m_next_ok [2];
  int   m_idle [2];
  int   m_cyc;
  logic m_prev [4];

  af_setpoint_ctrl #(.W(W), .A_INIT(5), .F_INIT(5), .A_MAX(15), .F_MAX(15), .STEP(1),
                     .HOLDOFF(16), .DECAY_CYCLES(DECAY)) u_dut1 (
    .clk(clk), .reset(reset), .a_up(a_up), .a_down(a_down), .f_up(f_up), .f_down(f_down),
    .A(a1), .F(f1), .f_zero(f_zero1), .af_zero(af_zero1), .a_at_max(a_at_max1),
    .f_at_max(f_at_max1), .busy(busy1));

  af_setpoint_ctrl #(.W(W), .A_INIT(5), .F_INIT(5), .A_MAX(15), .F_MAX(13), .STEP(2),
                     .HOLDOFF(12), .DECAY_CYCLES(DECAY)) u_dut2 (
    .clk(clk), .reset(reset), .a_up(a_up), .a_down(a_down), .f_up(f_up), .f_down(f_down),
    .A(a2), .F(f2), .f_zero(f_zero2), .af_zero(af_zero2), .a_at_max(a_at_max2),
    .f_at_max(f_at_max2), .busy(busy2));

  always #5 clk = ~clk;

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_a[i]       = 5;
      m_f[i]       = 5;
      m_next_ok[i] = 0;
      m_idle[i]    = 0;
    end
    for (int k = 0; k < 4; k++) m_prev[k] = 1'b0;
  endtask

  // Predicts the effect of the next rising edge using the inputs currently driven.
  task automatic modelStep();
    logic e_au, e_ad, e_fu, e_fd;
    e_au = a_up & ~m_prev[0];
    e_ad = a_down & ~m_prev[1];
    e_fu = f_up & ~m_prev[2];
    e_fd = f_down & ~m_prev[3];
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      if (m_cyc >= m_next_ok[i] && (e_au || e_ad || e_fu || e_fd)) begin
        if (e_au && !e_ad)      m_a[i] = imin(m_a[i] + m_step[i], m_amax[i]);
        else if (e_ad && !e_au) m_a[i] = (m_a[i] < m_step[i]) ? 0 : m_a[i] - m_step[i];
        if (e_fu && !e_fd)      m_f[i] = imin(m_f[i] + m_step[i], m_fmax[i]);
        else if (e_fd && !e_fu) m_f[i] = (m_f[i] < m_step[i]) ? 0 : m_f[i] - m_step[i];
        m_next_ok[i] = m_cyc + m_hold[i];
        m_idle[i]    = 0;
      end
`ifdef AF_AUTO_DECAY_EN
      else if (m_cyc > m_next_ok[i]) begin
        m_idle[i]++;
        if (m_idle[i] == DECAY) begin
          m_a[i]    = (m_a[i] < m_step[i]) ? 0 : m_a[i] - m_step[i];
          m_idle[i] = 0;
        end
      end
`endif
    end
    m_prev[0] = a_up;
    m_prev[1] = a_down;
    m_prev[2] = f_up;
    m_prev[3] = f_down;
  endtask

  task automatic compareInst(input int i, input string name, input logic [W-1:0] a, input logic [W-1:0] f,
                             input logic fz, input logic afz, input logic amx, input logic fmx, input logic bsy);
    checkOutput({name, ".A"}, a, m_a[i]);
    checkOutput({name, ".F"}, f, m_f[i]);
    checkOutput({name, ".f_zero"}, fz, m_f[i] == 0);
    checkOutput({name, ".af_zero"}, afz, (m_a[i] == 0) && (m_f[i] == 0));
    checkOutput({name, ".a_at_max"}, amx, m_a[i] == m_amax[i]);
    checkOutput({name, ".f_at_max"}, fmx, m_f[i] == m_fmax[i]);
    checkOutput({name, ".busy"}, bsy, m_cyc < m_next_ok[i]);
  endtask

  task automatic compareAll();
    compareInst(0, "u1", a1, f1, f_zero1, af_zero1, a_at_max1, f_at_max1, busy1);
    compareInst(1, "u2", a2, f2, f_zero2, af_zero2, a_at_max2, f_at_max2, busy2);
  endtask

  // One cycle per iteration: check the previous edge's result, then drive the next inputs.
  task automatic applyStimulus(input logic au, input logic ad, input logic fu, input logic fd, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      compareAll();
      a_up   = au;
      a_down = ad;
      f_up   = fu;
      f_down = fd;
      modelStep();
    end
  endtask

  task automatic doReset(input logic au);
    @(negedge clk);
    reset  = 1'b0;
    a_up   = au;
    a_down = 1'b0;
    f_up   = 1'b0;
    f_down = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    modelStep();
  endtask

  initial begin
    int busy_cycles;
    int f2_exp [4] = '{3, 1, 0, 0};
    logic nau, nad, nfu, nfd;

    modelReset();
    doReset(1'b0);
    checkOutput("rst.A", a1, 5);
    checkOutput("rst.F", f1, 5);
    checkOutput("rst.busy", busy1, 0);
    checkOutput("rst.flags", {f_zero1, af_zero1, a_at_max1, f_at_max1}, 0);

    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("a_down_step", a1, 4);
    busy_cycles = busy1;
    for (int j = 0; j < 20; j++) begin
      applyStimulus(0, j == 3, 0, 0, 1);
      busy_cycles += busy1;
    end
    checkOutput("holdoff_discard", a1, 4);
    checkOutput("busy_len", busy_cycles, 16);

    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("hold_busy", busy1, 1);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst.A", a1, 5);
    checkOutput("async_rst.F", f1, 5);
    checkOutput("async_rst.busy", busy1, 0);
    checkOutput("async_rst.A2", a2, 5);
    checkOutput("async_rst.busy2", busy2, 0);
    doReset(1'b0);

    for (int p = 0; p < 4; p++) begin
      applyStimulus(0, 1, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 19);
      checkOutput("f_down_sat", f2, f2_exp[p]);
      checkOutput("f_zero", f_zero2, p >= 2);
      checkOutput("af_zero", af_zero2, p >= 2);
      checkOutput("a_down_u1", a1, 4 - p);
    end

    for (int p = 1; p <= 9; p++) begin
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 19);
      checkOutput("a_up_sat", a2, imin(2 * p, 15));
      checkOutput("a_up_u1", a1, 1 + p);
    end
    checkOutput("a_at_max", a_at_max2, 1);
    checkOutput("a_not_max", a_at_max1, 0);

    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("cancel.A1", a1, 10);
    checkOutput("cancel.A2", a2, 15);
    checkOutput("cancel.busy1", busy1, 1);
    checkOutput("cancel.busy2", busy2, 1);
    applyStimulus(0, 0, 0, 0, 18);

    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("both.A1", a1, 11);
    checkOutput("both.F1", f1, 2);
    checkOutput("both.F2", f2, 2);
    applyStimulus(0, 0, 0, 0, 19);

    doReset(1'b1);
    applyStimulus(1, 0, 0, 0, 100);
    checkOutput("held.F1", f1, 5);
`ifndef AF_AUTO_DECAY_EN
    checkOutput("held.A1", a1, 6);
    checkOutput("held.A2", a2, 7);
    checkOutput("held.busy1", busy1, 0);
`endif
    applyStimulus(0, 0, 0, 0, 20);

`ifdef AF_AUTO_DECAY_EN
    doReset(1'b0);
    applyStimulus(0, 0, 0, 0, 16);
    checkOutput("decay.16", a1, 3);
    applyStimulus(0, 0, 0, 0, 7);
    checkOutput("decay.23", a1, 3);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("decay.24", a1, 2);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("decay.32", a1, 1);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("decay.40", a1, 0);
    applyStimulus(0, 0, 0, 0, 20);
    checkOutput("decay.floor", a1, 0);

    doReset(1'b0);
    applyStimulus(0, 0, 0, 0, 6);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("decay.req_wins", a1, 6);
    applyStimulus(1, 0, 0, 0, 23);
    checkOutput("decay.restart31", a1, 6);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("decay.restart32", a1, 5);
    applyStimulus(0, 0, 0, 0, 4);
`endif

    for (int c = 0; c < 800; c++) begin
      nau = ($urandom_range(0, 7) == 0) ? ~a_up : a_up;
      nad = ($urandom_range(0, 7) == 0) ? ~a_down : a_down;
      nfu = ($urandom_range(0, 7) == 0) ? ~f_up : f_up;
      nfd = ($urandom_range(0, 7) == 0) ? ~f_down : f_down;
      applyStimulus(nau, nad, nfu, nfd, 1);
    end
    applyStimulus(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
